// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with thresholds, fill level, standard/FWFT read and sticky errors
module sync_fifo_param #(
  parameter int Data_Width = 8,
  parameter int Addr_Size  = 3,
  parameter int AF_Level   = 6,
  parameter int AE_Level   = 1,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [Data_Width-1:0] W_Data,
  input  logic                  R_INC,
  input  logic                  Clr_Err,
  output logic [Data_Width-1:0] R_Data,
  output logic                  R_Valid,
  output logic                  FIFO_Full,
  output logic                  FIFO_Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [Addr_Size:0]    Fill_Count,
  output logic                  Overflow,
  output logic                  Underflow
);
  localparam int Depth = 1 << Addr_Size;
  localparam logic [Addr_Size:0]   DEPTH_C = (Addr_Size+1)'(Depth);
  localparam logic [Addr_Size:0]   AF_C    = (Addr_Size+1)'(AF_Level);
  localparam logic [Addr_Size:0]   AE_C    = (Addr_Size+1)'(AE_Level);
  localparam logic [Addr_Size:0]   CNT_ONE = 1;
  localparam logic [Addr_Size-1:0] PTR_ONE = 1;
  logic [Data_Width-1:0] mem [Depth];
  logic [Addr_Size-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Addr_Size:0]    count_q, count_d;
  logic [Data_Width-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d, ovf_q, ovf_d, unf_q, unf_d, rd_ok, wr_ok;
  assign FIFO_Full    = count_q == DEPTH_C;
  assign FIFO_Empty   = count_q == '0;
  assign Almost_Full  = count_q >= AF_C;
  assign Almost_Empty = count_q <= AE_C;
  assign Fill_Count   = count_q;
  assign Overflow     = ovf_q;
  assign Underflow    = unf_q;
  // in FWFT mode the head word is presented combinationally; zero while empty
  assign R_Data  = FWFT != 0 ? (FIFO_Empty ? '0 : mem[rd_ptr_q]) : rdata_q;
  assign R_Valid = FWFT != 0 ? ~FIFO_Empty : rvalid_q;
  // acceptance, pointer/count advance, registered read data and sticky error next-state
  always_comb begin
    rd_ok    = R_INC & ~FIFO_Empty;
    wr_ok    = W_INC & (~FIFO_Full | rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = (wr_ok & ~rd_ok) ? count_q + CNT_ONE :
               (rd_ok & ~wr_ok) ? count_q - CNT_ONE : count_q;
    rdata_d  = rd_ok ? mem[rd_ptr_q] : rdata_q;
    rvalid_d = rd_ok;
    ovf_d    = (W_INC & ~wr_ok) | (ovf_q & ~Clr_Err);
    unf_d    = (R_INC & FIFO_Empty) | (unf_q & ~Clr_Err);
  end
  // control state, cleared asynchronously so a reset discards contents at once
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  // storage array is deliberately left out of reset
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr_q] <= W_Data;
  end
endmodule
